// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, redirect and decode handshake.
// master = fetch unit side, slave = memory/decode/branch environment side.
interface fetch_unit_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [DATA_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [31:0]           imem_rsp_data;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  id_valid;
  logic                  id_ready;
  logic [31:0]           id_inst;
  logic [DATA_WIDTH-1:0] id_pc;
  logic                  id_illegal;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output id_valid, id_inst, id_pc, id_illegal,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  id_valid, id_inst, id_pc, id_illegal,
    output id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response pairing, decode FIFO.
// Optional illegal-opcode flag on the FIFO head is built only when FETCH_ILLEGAL_CHECK_EN is defined.
//
// state | meaning
// BOOT  | one idle cycle after reset release, no requests issued, responses ignored
// RUN   | normal fetch operation until the next reset
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    BUF_DEPTH  = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {BOOT, RUN} state_t;

  state_t state, state_nxt;
  logic   run;

  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [CW-1:0]         out_cnt;
  logic [CW-1:0]         discard_cnt;
  logic [CW-1:0]         buf_cnt;
  logic [CW:0]           credit_used;

  logic req_valid;
  logic req_fire;
  logic rsp_fire;
  logic rsp_stale;
  logic buf_wr;
  logic buf_pop;
  logic head_valid;

  // PC of every accepted request, popped in order as responses return
  logic [DATA_WIDTH-1:0] pcq [BUF_DEPTH];
  logic [PW-1:0]         pcq_wr;
  logic [PW-1:0]         pcq_rd;

  logic [31:0]           buf_inst [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] buf_pc   [BUF_DEPTH];
  logic [PW-1:0]         buf_wr_ptr;
  logic [PW-1:0]         buf_rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    run = 1'b0;
    case (state)
      RUN:     run = 1'b1;
      default: run = 1'b0;
    endcase
  end

  // Stale requests still hold credit until their responses come back
  always_comb begin
    credit_used = {1'b0, out_cnt} + {1'b0, buf_cnt};
    req_valid   = run && !bus.redirect_valid && (credit_used < (CW+1)'(BUF_DEPTH));
    req_fire    = req_valid && bus.imem_req_ready;
    rsp_fire    = run && bus.imem_rsp_valid && (out_cnt != '0);
    rsp_stale   = bus.redirect_valid || (discard_cnt != '0);
    buf_wr      = rsp_fire && !rsp_stale;
    head_valid  = (buf_cnt != '0);
    buf_pop     = head_valid && bus.id_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + DATA_WIDTH'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else begin
      out_cnt <= out_cnt + CW'(req_fire) - CW'(rsp_fire);
    end
  end

  // On redirect everything still in flight becomes stale, including older stale ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard_cnt <= '0;
    end else if (bus.redirect_valid) begin
      discard_cnt <= out_cnt - CW'(rsp_fire);
    end else if (rsp_fire && (discard_cnt != '0)) begin
      discard_cnt <= discard_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcq_wr <= '0;
      pcq_rd <= '0;
    end else begin
      if (req_fire) begin
        pcq_wr <= pcq_wr + PW'(1);
      end
      if (rsp_fire) begin
        pcq_rd <= pcq_rd + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq[pcq_wr] <= fetch_pc;
    end
  end

  // Flush drops whatever the pop in the same cycle did not already deliver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_wr_ptr <= '0;
      buf_rd_ptr <= '0;
      buf_cnt    <= '0;
    end else if (bus.redirect_valid) begin
      buf_wr_ptr <= '0;
      buf_rd_ptr <= '0;
      buf_cnt    <= '0;
    end else begin
      if (buf_wr) begin
        buf_wr_ptr <= buf_wr_ptr + PW'(1);
      end
      if (buf_pop) begin
        buf_rd_ptr <= buf_rd_ptr + PW'(1);
      end
      buf_cnt <= buf_cnt + CW'(buf_wr) - CW'(buf_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (buf_wr) begin
      buf_inst[buf_wr_ptr] <= bus.imem_rsp_data;
      buf_pc[buf_wr_ptr]   <= pcq[pcq_rd];
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.id_valid       = head_valid;
  assign bus.id_inst        = head_valid ? buf_inst[buf_rd_ptr] : 32'h0;
  assign bus.id_pc          = head_valid ? buf_pc[buf_rd_ptr] : '0;

`ifdef FETCH_ILLEGAL_CHECK_EN
  logic [31:0] head_inst;
  logic        head_bad;

  always_comb begin
    head_inst = buf_inst[buf_rd_ptr];
    head_bad  = (head_inst[1:0] != 2'b11)
             || (head_inst[6:0] == 7'h00)
             || (head_inst[6:0] == 7'h7f);
  end

  assign bus.id_illegal = head_valid && head_bad;
`else
  assign bus.id_illegal = 1'b0;
`endif

endmodule
